// File: rtl/tdm_demux.sv
// Receive side of a 2-lane bit-interleaved link: routes serial bits to lanes and assembles word pairs.
// Optional per-lane even parity bit per frame when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_sync,
  input  logic             word_ack,
  output logic [WIDTH-1:0] lane0_word,
  output logic [WIDTH-1:0] lane1_word,
  output logic             word_valid,
  output logic             lane_sel,
  output logic             overrun,
  output logic             parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] shreg0, shreg1;
  logic [WIDTH-1:0] next1;
  logic [CW-1:0]    count;
  logic             complete;
  logic             data_phase;

  // The parity pair occupies the final count slot and is never shifted into the words.
  always_comb begin
`ifdef TDM_DEMUX_PARITY_EN
    data_phase = (count != LAST);
`else
    data_phase = 1'b1;
`endif
    complete = bit_valid && !frame_sync && lane_sel && (count == LAST);
    next1    = data_phase ? {shreg1[WIDTH-2:0], bit_in} : shreg1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg0   <= '0;
      shreg1   <= '0;
      count    <= '0;
      lane_sel <= 1'b0;
    end else if (frame_sync) begin
      shreg1 <= '0;
      count  <= '0;
      if (bit_valid) begin
        shreg0   <= {{(WIDTH-1){1'b0}}, bit_in};
        lane_sel <= 1'b1;
      end else begin
        shreg0   <= '0;
        lane_sel <= 1'b0;
      end
    end else if (bit_valid) begin
      if (!lane_sel) begin
        if (data_phase) shreg0 <= {shreg0[WIDTH-2:0], bit_in};
        lane_sel <= 1'b1;
      end else begin
        shreg1   <= next1;
        lane_sel <= 1'b0;
        count    <= (count == LAST) ? '0 : count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane0_word <= '0;
      lane1_word <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (complete && (!word_valid || word_ack)) begin
      lane0_word <= shreg0;
      lane1_word <= next1;
      word_valid <= 1'b1;
    end else if (complete) begin
      overrun <= 1'b1;
    end else if (word_ack && word_valid) begin
      word_valid <= 1'b0;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic par0;
  logic pair_err;

  always_comb begin
    pair_err = (^shreg0 ^ par0) | (^shreg1 ^ bit_in);
  end

  // Lane0 parity bit is held until its lane1 partner arrives and completes the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par0       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (bit_valid && !frame_sync && !lane_sel && !data_phase) par0 <= bit_in;
      if (complete && (!word_valid || word_ack)) parity_err <= pair_err;
      else if (!complete && word_ack && word_valid) parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: randomized and directed frames against a position-based frame model.
module tb_tdm_demux;
  localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic bit_in = 1'b0, bit_valid = 1'b0, frame_sync = 1'b0, word_ack = 1'b0;
  logic [W-1:0] lane0_word, lane1_word;
  logic word_valid, lane_sel, overrun, parity_err;

  int total = 0;
  int bad = 0;

  logic [2*W:0] expQ[$];
  int pos = 0;
  int unsigned cur0 = 0, cur1 = 0;
  bit p0 = 0, p1 = 0;
  bit pending = 0;
  bit expOverrun = 0;

  tdm_demux #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_sync(frame_sync), .word_ack(word_ack), .lane0_word(lane0_word),
    .lane1_word(lane1_word), .word_valid(word_valid), .lane_sel(lane_sel),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Frame model: a bit position within the frame, plus the pair acceptance rule.
  task automatic modelStep(bit bv, bit b, bit fs, bit ack);
    bit done = 0;
    int idx;
    bit perr;
    if (fs) begin
      pos = 0; cur0 = 0; cur1 = 0;
    end
    if (bv) begin
      idx = pos / 2;
      if (pos % 2 == 0) begin
        if (idx < W) cur0 = ((cur0 << 1) | b) & ((1 << W) - 1);
        else p0 = b;
      end else begin
        if (idx < W) cur1 = ((cur1 << 1) | b) & ((1 << W) - 1);
        else p1 = b;
      end
      pos++;
      if (pos == 2 * FL) begin
        done = 1;
        pos = 0;
      end
    end
    if (done) begin
      if (!pending || ack) begin
        perr = (FL > W) ? (((^cur0[W-1:0]) ^ p0) | ((^cur1[W-1:0]) ^ p1)) : 1'b0;
        expQ.push_back({perr, cur0[W-1:0], cur1[W-1:0]});
        pending = 1;
      end else begin
        expOverrun = 1;
      end
    end else if (ack && pending) begin
      pending = 0;
    end
  endtask

  task automatic applyStimulus(bit bv, bit b, bit fs, bit ack);
    @(negedge clk);
    bit_valid = bv; bit_in = b; frame_sync = fs; word_ack = ack;
    @(posedge clk);
    modelStep(bv, b, fs, ack);
    #1;
    checkOutput("lane_sel", {31'd0, lane_sel}, pos % 2);
    checkOutput("word_valid", {31'd0, word_valid}, {31'd0, pending});
    checkOutput("overrun", {31'd0, overrun}, {31'd0, expOverrun});
  endtask

  task automatic sendFrame(logic [W-1:0] w0, logic [W-1:0] w1, int gap, bit sync,
                           bit ackLast, bit flip, bit rndAck);
    logic [W-1:0] a, c;
    bit b0, b1, k;
    a = w0; c = w1;
    for (int i = 0; i < FL; i++) begin
      if (i < W) begin
        b0 = a[W-1-i]; b1 = c[W-1-i];
      end else begin
        b0 = ^a; b1 = (^c) ^ flip;
      end
      k = rndAck && ($urandom % 4 == 0);
      applyStimulus(1, b0, sync && (i == 0), k);
      for (int g = 0; g < gap; g++) applyStimulus(0, 0, 0, rndAck && ($urandom % 4 == 0));
      k = (ackLast && i == FL - 1) || (rndAck && ($urandom % 4 == 0));
      applyStimulus(1, b1, 0, k);
      if (i != FL - 1)
        for (int g = 0; g < gap; g++) applyStimulus(0, 0, 0, rndAck && ($urandom % 4 == 0));
    end
  endtask

  task automatic asyncReset();
    @(negedge clk);
    bit_valid = 0; frame_sync = 0; word_ack = 0;
    #2 rst_n = 0;
    #1;
    checkOutput("rst word_valid", {31'd0, word_valid}, 0);
    checkOutput("rst lane0_word", {24'd0, lane0_word}, 0);
    checkOutput("rst lane1_word", {24'd0, lane1_word}, 0);
    checkOutput("rst overrun", {31'd0, overrun}, 0);
    checkOutput("rst lane_sel", {31'd0, lane_sel}, 0);
    pos = 0; cur0 = 0; cur1 = 0; pending = 0; expOverrun = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Monitor: a pair is presented when word_valid rises or reloads across an ack.
  always @(posedge clk) begin
    logic wasValid, ackNow;
    logic [2*W:0] e;
    wasValid = word_valid;
    ackNow = word_ack;
    #2;
    if (rst_n && word_valid && (!wasValid || ackNow)) begin
      if (expQ.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected pair: got %0h/%0h, expected none", lane0_word, lane1_word);
      end else begin
        e = expQ.pop_front();
        checkOutput("lane0_word", {24'd0, lane0_word}, {24'd0, e[2*W-1:W]});
        checkOutput("lane1_word", {24'd0, lane1_word}, {24'd0, e[W-1:0]});
        checkOutput("parity_err", {31'd0, parity_err}, {31'd0, e[2*W]});
      end
    end
  end

  initial begin
    rst_n = 1;
    #1 rst_n = 0;
    #22;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("idle lane0_word", {24'd0, lane0_word}, 0);
    checkOutput("idle parity_err", {31'd0, parity_err}, 0);

    sendFrame(8'hA5, 8'h3C, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    sendFrame(8'hA5, 8'h3C, 3, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);

    sendFrame(8'h11, 8'h22, 0, 1, 0, 0, 0);
    sendFrame(8'h33, 8'h44, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    sendFrame(8'h55, 8'h66, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);

    for (int i = 0; i < 5; i++) applyStimulus(1, i[0], i == 0, 0);
    asyncReset();
    sendFrame(8'hC3, 8'h5A, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);

    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    sendFrame(8'hFF, 8'h00, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);

    sendFrame(8'h12, 8'h34, 0, 1, 0, 0, 0);
    sendFrame(8'h0F, 8'hF0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);

    sendFrame(8'hA5, 8'h3C, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    sendFrame(8'hA5, 8'h3C, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);

    for (int f = 0; f < 20; f++)
      sendFrame(W'($urandom), W'($urandom), $urandom_range(0, 2), 1, 0, f[0], 1);

    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("queue drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
